// File: rtl/predictor_pkg.sv
// ---------------------------------------------------------------------------
// predictor_pkg
// Shared constants for the branch history table predictor:
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - widths of the fields packed into an in-flight queue entry
//   - sat_update(): one saturating step of a counter toward taken/not-taken
// ---------------------------------------------------------------------------
package predictor_pkg;

    // 2-bit counter states; bit [1] is the taken/not-taken prediction
    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    // Queue-entry field widths (the index field width is a module parameter)
    localparam int CNT_W  = 2;
    localparam int PRED_W = 1;
    localparam int ADDR_W = 32;

    // One saturating step: +1 when taken, -1 when not taken, clamped to [SNT, ST]
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                    input logic             taken);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != ST) begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// ---------------------------------------------------------------------------
// bht_predictor_if
// Bundles every non-clock/reset signal of the predictor.
//   master : the pipeline side (IF requests, commit-stage resolution, rdy)
//   slave  : the predictor itself
// Request side : rdy, ask_predictor, pc_from_if, jump_addr_from_if,
//                next_addr_from_if, now_ins_jalr
// Response side: jump, predictor_sgn_rdy, predictor_occupied, if_flush,
//                addr_to_if
// Commit side  : branch_commit, branch_jump, jalr_commit, jalr_addr
// ---------------------------------------------------------------------------
interface bht_predictor_if;
    logic        rdy;
    logic        ask_predictor;
    logic [31:0] pc_from_if;
    logic [31:0] jump_addr_from_if;
    logic [31:0] next_addr_from_if;
    logic        now_ins_jalr;

    logic        jump;
    logic        predictor_sgn_rdy;
    logic        predictor_occupied;
    logic        if_flush;
    logic [31:0] addr_to_if;

    logic        branch_commit;
    logic        branch_jump;
    logic        jalr_commit;
    logic [31:0] jalr_addr;

    modport master (
        output rdy, ask_predictor, pc_from_if, jump_addr_from_if,
               next_addr_from_if, now_ins_jalr,
               branch_commit, branch_jump, jalr_commit, jalr_addr,
        input  jump, predictor_sgn_rdy, predictor_occupied, if_flush, addr_to_if
    );

    modport slave (
        input  rdy, ask_predictor, pc_from_if, jump_addr_from_if,
               next_addr_from_if, now_ins_jalr,
               branch_commit, branch_jump, jalr_commit, jalr_addr,
        output jump, predictor_sgn_rdy, predictor_occupied, if_flush, addr_to_if
    );
endinterface

// File: rtl/pred_fifo.sv
// ---------------------------------------------------------------------------
// pred_fifo
// Small first-word-fall-through FIFO holding in-flight branch entries.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write an entry (ignored when full unless popping, or clear)
//   pop, dout       dout always shows the oldest entry; pop retires it
//   clear           empty the FIFO at the next edge (wins over push/pop)
//   full            registered, high when DEPTH entries are held
//   empty           high when no entries are held
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module pred_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = full_q;
    assign dout  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_push = push & ~clear & (~full_q | pop);
    assign do_pop  = pop  & ~clear & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor
// Branch history table of 2^IDX_W two-bit saturating counters indexed by
// pc[IDX_W+1:2], plus a queue of in-flight predicted branches that is
// retired in program order by the commit stage.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  bht_predictor_if.slave: IF request/response, commit resolution,
//        global enable rdy
// Behaviour summary:
//   - prediction is combinational in the request cycle (JALR -> not taken)
//   - accepted non-JALR requests are queued; branch_commit retires the head
//     and trains its counter
//   - a mispredicted branch or a resolved JALR produces a one-cycle
//     if_flush with the redirect address and empties the queue
// ---------------------------------------------------------------------------
module bht_predictor
    import predictor_pkg::*;
#(
    parameter int         IDX_W    = 6,
    parameter int         DEPTH    = 4,
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic            clk,
    input  logic            rst,
    bht_predictor_if.slave  bus
);
    localparam int N_CNT   = 1 << IDX_W;
    localparam int ENTRY_W = IDX_W + PRED_W + 2 * ADDR_W;

    // ---------------- lookup ----------------
    logic [N_CNT-1:0][CNT_W-1:0] cnt_vec;
    logic [IDX_W-1:0]            req_idx;
    logic [CNT_W-1:0]            lookup_cnt;

    assign req_idx    = bus.pc_from_if[IDX_W+1:2];
    // Counters only change at the clock edge, so a same-cycle update to this
    // index is not yet visible here: the lookup sees the pre-update value.
    assign lookup_cnt = cnt_vec[req_idx];
    assign bus.jump   = ~bus.now_ins_jalr & lookup_cnt[1];

    // ---------------- in-flight queue ----------------
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic               fifo_full, fifo_empty;
    logic               do_push, do_pop, flush_now;

    logic [IDX_W-1:0]   head_idx;
    logic               head_pred;
    logic [ADDR_W-1:0]  head_jump_addr, head_next_addr;

    assign push_entry = {req_idx, lookup_cnt[1], bus.jump_addr_from_if, bus.next_addr_from_if};

    assign head_idx       = head_entry[ENTRY_W-1 -: IDX_W];
    assign head_pred      = head_entry[2*ADDR_W];
    assign head_jump_addr = head_entry[2*ADDR_W-1 -: ADDR_W];
    assign head_next_addr = head_entry[ADDR_W-1:0];

    pred_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .clear (flush_now),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------- control ----------------
    logic              mispredict, jalr_redirect, sgn_rdy;
    logic              if_flush_q, if_flush_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        // rdy gates every state-changing action; a commit on an empty queue
        // has nothing to retire and is dropped.
        do_pop        = bus.rdy & bus.branch_commit & ~fifo_empty;
        mispredict    = do_pop & (bus.branch_jump != head_pred);
        jalr_redirect = bus.rdy & bus.jalr_commit;
        flush_now     = mispredict | jalr_redirect;

        // A retiring head frees a slot this cycle, so a full queue still accepts.
        sgn_rdy = bus.ask_predictor & bus.rdy &
                  (bus.now_ins_jalr | ~fifo_full | do_pop);
        // A request younger than a redirecting commit is on the wrong path.
        do_push = sgn_rdy & ~bus.now_ins_jalr & ~flush_now;

        if_flush_d = flush_now;
        addr_d     = addr_q;
        // The branch is older than the JALR, so its redirect takes precedence.
        if (mispredict) begin
            addr_d = bus.branch_jump ? head_jump_addr : head_next_addr;
        end else if (jalr_redirect) begin
            addr_d = bus.jalr_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_flush_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            if_flush_q <= if_flush_d;
            addr_q     <= addr_d;
        end
    end

    assign bus.predictor_sgn_rdy  = sgn_rdy;
    assign bus.predictor_occupied = fifo_full;
    assign bus.if_flush           = if_flush_q;
    assign bus.addr_to_if         = addr_q;

    // ---------------- counter table ----------------
    // Every retired branch trains the counter it was predicted from,
    // including mispredicted ones.
    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            logic             upd;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            assign upd = do_pop & (head_idx == IDX_W'(gi));

            always_comb begin
                cnt_d = cnt_q;
                if (upd) begin
                    cnt_d = sat_update(cnt_q, bus.branch_jump);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= CNT_INIT;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    // Address bits outside the index and the counter's low bit are not needed.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.pc_from_if[31:IDX_W+2], bus.pc_from_if[1:0], lookup_cnt[0]};

endmodule

// File: tb/tb_bht_predictor.sv
// ---------------------------------------------------------------------------
// tb_bht_predictor
// Drives directed scenarios followed by randomized traffic. For every cycle
// the driver computes the expected outputs from a queue/array reference
// model and pushes them to a scoreboard; a monitor on the falling edge pops
// each record and compares it with what the predictor presents.
// ---------------------------------------------------------------------------
module tb_bht_predictor;
    localparam int         IDX_W    = 6;
    localparam int         DEPTH    = 4;
    localparam logic [1:0] CNT_INIT = 2'b01;
    localparam int         N_CNT    = 1 << IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bht_predictor_if bif ();

    bht_predictor #(
        .IDX_W    (IDX_W),
        .DEPTH    (DEPTH),
        .CNT_INIT (CNT_INIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        int          idx;
        bit          pred;
        logic [31:0] ja;
        logic [31:0] na;
    } entry_t;

    typedef struct {
        int          cyc;
        bit          chk_jump;
        bit          exp_jump;
        bit          exp_rdy;
        bit          exp_occ;
        bit          exp_flush;
        bit          chk_addr;
        logic [31:0] exp_addr;
    } exp_t;

    // reference model state
    entry_t      inflight[$];
    int          model_cnt[N_CNT];
    bit          flush_pend;
    logic [31:0] flush_addr;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    // stimulus for the next cycle; cleared after each tick
    bit          s_rst = 1'b0, s_rdy = 1'b1, s_ask = 1'b0, s_jalr = 1'b0;
    bit          s_bc = 1'b0, s_bj = 1'b0, s_jc = 1'b0;
    logic [31:0] s_pc = '0, s_ja = '0, s_na = '0, s_jaddr = '0;

    task automatic clear_stim();
        s_rst = 1'b0; s_rdy = 1'b1; s_ask = 1'b0; s_jalr = 1'b0;
        s_bc = 1'b0; s_bj = 1'b0; s_jc = 1'b0;
        s_pc = '0; s_ja = '0; s_na = '0; s_jaddr = '0;
    endtask

    task automatic tick();
        exp_t   e;
        entry_t head;
        entry_t ne;
        int     idx;
        bit     occ, pop, mis;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) begin
            s_ask = 1'b0; s_bc = 1'b0; s_jc = 1'b0; s_jalr = 1'b0;
        end
        rst                   = s_rst;
        bif.rdy               = s_rdy;
        bif.ask_predictor     = s_ask;
        bif.pc_from_if        = s_pc;
        bif.jump_addr_from_if = s_ja;
        bif.next_addr_from_if = s_na;
        bif.now_ins_jalr      = s_jalr;
        bif.branch_commit     = s_bc;
        bif.branch_jump       = s_bj;
        bif.jalr_commit       = s_jc;
        bif.jalr_addr         = s_jaddr;

        e.cyc = cyc;
        if (s_rst) begin
            for (int i = 0; i < N_CNT; i++) model_cnt[i] = int'(CNT_INIT);
            inflight.delete();
            flush_pend = 1'b0;
            flush_addr = '0;
            e.chk_jump = 1'b0; e.exp_jump = 1'b0; e.exp_rdy = 1'b0;
            e.exp_occ = 1'b0; e.exp_flush = 1'b0; e.chk_addr = 1'b1; e.exp_addr = '0;
            sb.push_back(e);
        end else begin
            idx = int'((s_pc >> 2) % N_CNT);
            occ = (inflight.size() == DEPTH);
            pop = s_rdy && s_bc && (inflight.size() > 0);
            e.exp_occ   = occ;
            e.exp_flush = flush_pend;
            e.chk_addr  = flush_pend;
            e.exp_addr  = flush_addr;
            e.exp_rdy   = s_ask && s_rdy && (s_jalr || !occ || pop);
            e.chk_jump  = s_ask;
            e.exp_jump  = s_jalr ? 1'b0 : (model_cnt[idx] >= 2);
            sb.push_back(e);

            // effect of the coming clock edge
            flush_pend = 1'b0;
            if (s_rdy) begin
                mis = 1'b0;
                if (pop) begin
                    head = inflight.pop_front();
                    if (s_bj) model_cnt[head.idx] = (model_cnt[head.idx] == 3) ? 3 : model_cnt[head.idx] + 1;
                    else      model_cnt[head.idx] = (model_cnt[head.idx] == 0) ? 0 : model_cnt[head.idx] - 1;
                    mis = (s_bj != head.pred);
                end
                if (mis) begin
                    flush_pend = 1'b1;
                    flush_addr = s_bj ? head.ja : head.na;
                end else if (s_jc) begin
                    flush_pend = 1'b1;
                    flush_addr = s_jaddr;
                end
                if (flush_pend) begin
                    inflight.delete();
                end else if (e.exp_rdy && !s_jalr) begin
                    ne.idx = idx; ne.pred = e.exp_jump; ne.ja = s_ja; ne.na = s_na;
                    inflight.push_back(ne);
                end
            end
        end
        clear_stim();
    endtask

    task automatic check(string name, int c, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
        end
    endtask

    // monitor: one scoreboard record per cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            $display("cyc %0d rst=%0b ask=%0b sgn_rdy=%0b jump=%0b occ=%0b flush=%0b addr=%h",
                     e.cyc, rst, bif.ask_predictor, bif.predictor_sgn_rdy, bif.jump,
                     bif.predictor_occupied, bif.if_flush, bif.addr_to_if);
            check("sgn_rdy", e.cyc, 32'(bif.predictor_sgn_rdy), 32'(e.exp_rdy));
            check("occupied", e.cyc, 32'(bif.predictor_occupied), 32'(e.exp_occ));
            check("if_flush", e.cyc, 32'(bif.if_flush), 32'(e.exp_flush));
            if (e.chk_jump) check("jump", e.cyc, 32'(bif.jump), 32'(e.exp_jump));
            if (e.chk_addr) check("addr_to_if", e.cyc, bif.addr_to_if, e.exp_addr);
        end
    end

    task automatic req(logic [31:0] pc, logic [31:0] ja, logic [31:0] na);
        s_ask = 1'b1; s_pc = pc; s_ja = ja; s_na = na;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        clear_stim();
        do_reset();

        // train 0x100 from WNT: predict, commit taken, predict again
        req(32'h100, 32'h180, 32'h104); tick();
        s_bc = 1'b1; s_bj = 1'b1; tick();
        idle(2);
        req(32'h100, 32'h180, 32'h104); tick();
        s_bc = 1'b1; s_bj = 1'b1; tick();
        idle(2);

        // from ST, four not-taken commits walk the counter down to SNT
        for (int k = 0; k < 4; k++) begin
            req(32'h100, 32'h180, 32'h104); tick();
            s_bc = 1'b1; s_bj = 1'b0; tick();
            idle(2);
        end
        req(32'h100, 32'h180, 32'h104); tick();
        idle(1);
        s_bc = 1'b1; s_bj = 1'b0; tick();
        idle(1);

        // not-taken prediction at 0x200 resolved taken
        req(32'h200, 32'h300, 32'h204); tick();
        s_bc = 1'b1; s_bj = 1'b1; tick();
        idle(2);
        // branch commit on empty queue
        s_bc = 1'b1; s_bj = 1'b1; tick();
        idle(1);

        // fill the queue, try an extra request, then commit + request together
        for (int k = 0; k < DEPTH; k++) begin
            req(32'h400 + 32'(k * 4), 32'h500, 32'h404 + 32'(k * 4)); tick();
        end
        req(32'h440, 32'h500, 32'h444); tick();
        req(32'h440, 32'h500, 32'h444); s_bc = 1'b1; s_bj = 1'b0; tick();
        idle(1);
        for (int k = 0; k < DEPTH; k++) begin
            s_bc = 1'b1; s_bj = 1'b0; tick();
        end
        idle(1);

        // JALR resolution with three in flight, then with a branch mispredict
        for (int k = 0; k < 3; k++) begin
            req(32'h600 + 32'(k * 4), 32'h700, 32'h604 + 32'(k * 4)); tick();
        end
        s_jc = 1'b1; s_jaddr = 32'h8000; tick();
        idle(1);
        req(32'h650, 32'h900, 32'h654); s_jalr = 1'b1; tick();
        for (int k = 0; k < 3; k++) begin
            req(32'h600 + 32'(k * 4), 32'h700, 32'h604 + 32'(k * 4)); tick();
        end
        s_bc = 1'b1; s_bj = 1'b1; s_jc = 1'b1; s_jaddr = 32'h8000; tick();
        idle(2);

        // rdy low during a commit, then release and commit
        req(32'h800, 32'h880, 32'h804); tick();
        s_rdy = 1'b0; s_bc = 1'b1; s_bj = 1'b1; tick();
        s_rdy = 1'b0; s_jc = 1'b1; s_jaddr = 32'h1234; tick();
        s_bc = 1'b1; s_bj = 1'b1; tick();
        idle(2);

        // train 0x300 to ST, queue three branches, reset mid-queue
        for (int k = 0; k < 3; k++) begin
            req(32'h300, 32'h380, 32'h304); tick();
            s_bc = 1'b1; s_bj = 1'b1; tick();
            idle(1);
        end
        req(32'h300, 32'h380, 32'h304); tick();
        req(32'h300, 32'h380, 32'h304); tick();
        req(32'h300, 32'h380, 32'h304); tick();
        s_bc = 1'b1; s_bj = 1'b0; tick();
        do_reset();
        req(32'h300, 32'h380, 32'h304); tick();
        idle(2);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            s_rdy   = ($urandom_range(9) != 0);
            s_ask   = 1'($urandom_range(1));
            s_pc    = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(15)) << 2);
            s_ja    = $urandom;
            s_na    = $urandom;
            s_jalr  = ($urandom_range(9) == 0);
            s_bc    = ($urandom_range(2) == 0);
            s_bj    = 1'($urandom_range(1));
            s_jc    = ($urandom_range(24) == 0);
            s_jaddr = $urandom;
            s_rst   = ($urandom_range(149) == 0);
            tick();
        end
        idle(2);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d records left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
